// File: rtl/vram_cpu_pkg.sv
// Shared types for the 68k VRAM access port: register selects, port FSM states and write-queue entries.
package vram_cpu_pkg;

    localparam logic [1:0] SEL_ADDR   = 2'd0;
    localparam logic [1:0] SEL_RW     = 2'd1;
    localparam logic [1:0] SEL_MOD    = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } cpu_state_e;

    typedef struct packed {
        logic        zone;
        logic [14:0] addr;
        logic [15:0] data;
    } q_entry_t;

endpackage

// File: rtl/vram_cpu_fifo.sv
// Synchronous write queue for the VRAM CPU port; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module vram_cpu_fifo
    import vram_cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          CLK_24M,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  q_entry_t      din,
    output q_entry_t      dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    q_entry_t        mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK_24M) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vram_cpu_port.sv
// 68k register window onto VRAM: auto-incrementing address, queued writes and a prefetched read buffer.
// Define VRAMCPU_STATUS_EN to get the overflow flag and a live STATUS register.
module vram_cpu_port
    import vram_cpu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] MOD_RESET  = 16'd1
) (
    input  logic        CLK_24M,
    input  logic        RESET,
    input  logic [1:0]  REG_SEL,
    input  logic        REG_WR,
    input  logic        REG_RD,
    input  logic [15:0] REG_WRDATA,
    output logic [15:0] REG_RDDATA,
    output logic [14:0] CPU_ADDR,
    output logic [15:0] CPU_WRDATA,
    input  logic [15:0] CPU_RDDATA,
    output logic        CPU_PENDING,
    output logic        CPU_ZONE,
    output logic        CPU_RW,
    input  logic        CPU_ACK
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    cpu_state_e       state, state_nx;
    logic [15:0]      cur_addr, vram_mod, rdbuf, status_word, rd_mux;
    logic             rdreq;
    logic             wr_addr, wr_rw, wr_mod;
    logic             q_push, q_pop, q_full, q_empty;
    logic             rd_done, enter_wr, enter_rd;
    logic [CNT_W-1:0] q_count;
    q_entry_t         q_din, q_head;

    assign wr_addr  = REG_WR && (REG_SEL == SEL_ADDR);
    assign wr_rw    = REG_WR && (REG_SEL == SEL_RW);
    assign wr_mod   = REG_WR && (REG_SEL == SEL_MOD);

    assign q_pop    = (state == ST_WR) && CPU_ACK && !q_empty;
    assign rd_done  = (state == ST_RD) && CPU_ACK;
    assign q_push   = wr_rw && (!q_full || q_pop);
    assign q_din    = '{zone: cur_addr[15], addr: cur_addr[14:0], data: REG_WRDATA};

    assign enter_wr = (state == ST_IDLE) && (state_nx == ST_WR);
    assign enter_rd = (state == ST_IDLE) && (state_nx == ST_RD);

    assign CPU_PENDING = (state != ST_IDLE);

    vram_cpu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK_24M (CLK_24M),
        .RESET   (RESET),
        .push    (q_push),
        .pop     (q_pop),
        .din     (q_din),
        .dout    (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // Queued writes always win over the read prefetch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (q_count != '0) state_nx = ST_WR;
                else if (rdreq)    state_nx = ST_RD;
            end
            ST_WR:   if (CPU_ACK) state_nx = ST_IDLE;
            ST_RD:   if (CPU_ACK) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = rdbuf;
        case (REG_SEL)
            SEL_ADDR:   rd_mux = cur_addr;
            SEL_MOD:    rd_mux = vram_mod;
            SEL_STATUS: rd_mux = status_word;
            default:    rd_mux = rdbuf;
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            vram_mod   <= MOD_RESET;
            rdbuf      <= '0;
            rdreq      <= 1'b0;
            REG_RDDATA <= '0;
            CPU_ADDR   <= '0;
            CPU_WRDATA <= '0;
            CPU_ZONE   <= 1'b0;
            CPU_RW     <= 1'b1;
        end else begin
            state <= state_nx;

            if (wr_addr)     cur_addr <= REG_WRDATA;
            else if (q_push) cur_addr <= cur_addr + vram_mod;

            if (wr_mod)  vram_mod <= REG_WRDATA;
            if (rd_done) rdbuf    <= CPU_RDDATA;

            // The request is consumed when the read launches, so an address
            // write landing during the read leaves a fresh request behind.
            if (wr_addr || q_pop) rdreq <= 1'b1;
            else if (enter_rd)    rdreq <= 1'b0;

            if (enter_wr) begin
                CPU_ADDR   <= q_head.addr;
                CPU_ZONE   <= q_head.zone;
                CPU_WRDATA <= q_head.data;
                CPU_RW     <= 1'b0;
            end else if (enter_rd) begin
                CPU_ADDR   <= cur_addr[14:0];
                CPU_ZONE   <= cur_addr[15];
                CPU_RW     <= 1'b1;
            end

            if (REG_RD) REG_RDDATA <= rd_mux;
        end
    end

`ifdef VRAMCPU_STATUS_EN
    logic ovf;

    always_ff @(posedge CLK_24M) begin
        if (RESET)                                   ovf <= 1'b0;
        else if (wr_rw && !q_push)                   ovf <= 1'b1;
        else if (REG_WR && (REG_SEL == SEL_STATUS))  ovf <= 1'b0;
    end

    assign status_word = {ovf, CPU_PENDING, 4'(q_count), 10'b0};
`else
    assign status_word = 16'hFFFF;
`endif

endmodule

// File: tb/tb_vram_cpu_port.sv
// Randomized scoreboard bench for vram_cpu_port against a queue-based reference model.
module tb_vram_cpu_port;

    localparam int DEPTH = 2;

    logic        CLK_24M = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  REG_SEL = 2'd0;
    logic        REG_WR = 1'b0, REG_RD = 1'b0;
    logic [15:0] REG_WRDATA = 16'h0;
    logic [15:0] REG_RDDATA;
    logic [14:0] CPU_ADDR;
    logic [15:0] CPU_WRDATA;
    logic [15:0] CPU_RDDATA = 16'h0;
    logic        CPU_PENDING, CPU_ZONE, CPU_RW;
    logic        CPU_ACK = 1'b0;

    vram_cpu_port #(.FIFO_DEPTH(DEPTH), .MOD_RESET(16'd1)) dut (
        .CLK_24M     (CLK_24M),
        .RESET       (RESET),
        .REG_SEL     (REG_SEL),
        .REG_WR      (REG_WR),
        .REG_RD      (REG_RD),
        .REG_WRDATA  (REG_WRDATA),
        .REG_RDDATA  (REG_RDDATA),
        .CPU_ADDR    (CPU_ADDR),
        .CPU_WRDATA  (CPU_WRDATA),
        .CPU_RDDATA  (CPU_RDDATA),
        .CPU_PENDING (CPU_PENDING),
        .CPU_ZONE    (CPU_ZONE),
        .CPU_RW      (CPU_RW),
        .CPU_ACK     (CPU_ACK)
    );

    always #5 CLK_24M = ~CLK_24M;

    typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
    typedef struct packed { logic rw; logic [15:0] a; logic [15:0] d; } acc_t;

    int n_chk = 0, n_err = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: address/modulo registers, the write queue as a plain
    // list, one outstanding bus access, and the read-request flag.
    wr_t         mq[$];
    acc_t        exp_acc[$];
    logic [15:0] exp_rd[$];
    logic [15:0] m_addr, m_mod, m_rdbuf, m_lastrd;
    bit          m_rdreq, m_busy, m_kind_rd, m_pop, m_rdone;
    int          m_cnt;
    wr_t         m_tmp;
`ifdef VRAMCPU_STATUS_EN
    bit          m_ovf;
`endif

    function automatic logic [15:0] model_status();
`ifdef VRAMCPU_STATUS_EN
        return {m_ovf, m_busy, 4'(mq.size()), 10'b0};
`else
        return 16'hFFFF;
`endif
    endfunction

    always @(posedge CLK_24M) begin
        if (RESET) begin
            mq.delete();
            m_addr = 16'h0; m_mod = 16'd1; m_rdbuf = 16'h0; m_lastrd = 16'h0;
            m_rdreq = 0; m_busy = 0; m_kind_rd = 0;
`ifdef VRAMCPU_STATUS_EN
            m_ovf = 0;
`endif
        end else begin
            if (REG_RD) begin
                if (REG_SEL == 2'd1) begin m_lastrd = m_rdbuf; exp_rd.push_back(m_rdbuf); end
                if (REG_SEL == 2'd3) begin m_lastrd = model_status(); exp_rd.push_back(m_lastrd); end
            end
            m_pop   = m_busy && !m_kind_rd && CPU_ACK;
            m_rdone = m_busy &&  m_kind_rd && CPU_ACK;
            m_cnt   = mq.size();
            if (!m_busy) begin
                if (m_cnt > 0) begin
                    m_busy = 1; m_kind_rd = 0;
                    exp_acc.push_back(acc_t'{rw: 1'b0, a: mq[0].a, d: mq[0].d});
                end else if (m_rdreq) begin
                    m_busy = 1; m_kind_rd = 1; m_rdreq = 0;
                    exp_acc.push_back(acc_t'{rw: 1'b1, a: m_addr, d: 16'h0});
                end
            end else if (CPU_ACK) m_busy = 0;
            if (m_pop) begin m_tmp = mq.pop_front(); m_rdreq = 1; end
            if (m_rdone) m_rdbuf = CPU_RDDATA;
            if (REG_WR) begin
                case (REG_SEL)
                    2'd0: begin m_addr = REG_WRDATA; m_rdreq = 1; end
                    2'd1: begin
                        if (m_cnt < DEPTH || m_pop) begin
                            mq.push_back(wr_t'{a: m_addr, d: REG_WRDATA});
                            m_addr = m_addr + m_mod;
                        end
`ifdef VRAMCPU_STATUS_EN
                        else m_ovf = 1;
`endif
                    end
                    2'd2: m_mod = REG_WRDATA;
                    default: begin
`ifdef VRAMCPU_STATUS_EN
                        m_ovf = 0;
`endif
                    end
                endcase
            end
        end
    end

    // Bus responder: random-latency ACKs plus stray ACKs while idle, or
    // exact ACK placement from the stimulus process when auto_ack is off.
    bit auto_ack = 0, ack_now = 0;
    int dly = 0;
    always @(negedge CLK_24M) begin
        #1;
        if (!auto_ack) CPU_ACK = ack_now;
        else if (CPU_PENDING) begin
            if (dly == 0) begin CPU_ACK = 1'b1; dly = $urandom_range(0, 3); end
            else begin CPU_ACK = 1'b0; dly--; end
        end else CPU_ACK = ($urandom_range(0, 9) == 0);
        if (CPU_ACK) CPU_RDDATA = 16'($urandom);
    end

    // Monitor: pops the expected access when PENDING rises and holds it
    // against the bus for the whole access; pops register-read results.
    bit          chk_on = 0;
    logic        pend_prev = 1'b0;
    acc_t        cur = '0;
    logic [15:0] e_rd;
    always @(negedge CLK_24M) begin
        if (chk_on) begin
            check("pending", CPU_PENDING, m_busy);
            if (CPU_PENDING && !pend_prev) begin
                if (exp_acc.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL acc_unexpected: got rw=%b addr=%h expected no access", CPU_RW, CPU_ADDR);
                end else cur = exp_acc.pop_front();
            end
            if (CPU_PENDING) begin
                check("cpu_rw",   CPU_RW,   cur.rw);
                check("cpu_zone", CPU_ZONE, cur.a[15]);
                check("cpu_addr", CPU_ADDR, cur.a[14:0]);
                if (!cur.rw) check("cpu_wrdata", CPU_WRDATA, cur.d);
            end
            if (exp_rd.size() > 0) begin
                e_rd = exp_rd.pop_front();
                check("reg_rddata", REG_RDDATA, e_rd);
            end else check("rd_hold", REG_RDDATA, m_lastrd);
        end
        pend_prev = CPU_PENDING;
    end

    task automatic drive(input logic rst, input logic wr, input logic rd,
                         input logic [1:0] sel, input logic [15:0] d, input logic ack);
        @(negedge CLK_24M);
        RESET = rst; REG_WR = wr; REG_RD = rd; REG_SEL = sel; REG_WRDATA = d; ack_now = ack;
    endtask
    task automatic wreg(input logic [1:0] sel, input logic [15:0] d); drive(0, 1, 0, sel, d, 0); endtask
    task automatic rreg(input logic [1:0] sel); drive(0, 0, 1, sel, 16'h0, 0); endtask
    task automatic idle(input int n); repeat (n) drive(0, 0, 0, 2'd0, 16'h0, 0); endtask
    task automatic ack1(); drive(0, 0, 0, 2'd0, 16'h0, 1); endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pending"}, CPU_PENDING, 1'b0);
        check({tag, "_addr"},    CPU_ADDR,    15'h0);
        check({tag, "_wrdata"},  CPU_WRDATA,  16'h0);
        check({tag, "_zone"},    CPU_ZONE,    1'b0);
        check({tag, "_rw"},      CPU_RW,      1'b1);
        check({tag, "_rddata"},  REG_RDDATA,  16'h0);
    endtask

    int r;
    initial begin
        drive(1, 0, 0, 2'd0, 16'h0, 1);
        drive(1, 0, 0, 2'd0, 16'h0, 0);
        drive(1, 0, 0, 2'd0, 16'h0, 0);
        check_reset_outputs("rst");
        chk_on = 1;
        ack1();                       // stray ACK right after reset
        idle(3);
        rreg(2'd1);                   // read buffer is zero after reset
        idle(2);

        // ADDR 7000h, MOD 1, write 1234h
        auto_ack = 1;
        wreg(2'd0, 16'h7000); wreg(2'd2, 16'h0001); wreg(2'd1, 16'h1234);
        idle(25); rreg(2'd1); idle(2);

        // negative modulo wraps address 0000h to FFFFh (zone 1)
        wreg(2'd2, 16'hFFFF); wreg(2'd0, 16'h0000); wreg(2'd1, 16'h5A5A);
        idle(25); rreg(2'd1); idle(2);

        // fast-zone read, then address rewritten while the read is in flight
        auto_ack = 0;
        wreg(2'd2, 16'h0001); wreg(2'd0, 16'h8010); idle(3);
        wreg(2'd0, 16'h8020); idle(2); ack1(); idle(3);
        rreg(2'd1); idle(1); ack1(); idle(2); rreg(2'd1); idle(2);

        // overflow: no ACKs, three writes into a two-entry queue
        wreg(2'd0, 16'h0100); idle(3);
        wreg(2'd1, 16'hA001); wreg(2'd1, 16'hA002); wreg(2'd1, 16'hA003);
        idle(2); rreg(2'd3); idle(1); wreg(2'd3, 16'h0); rreg(2'd3);
        auto_ack = 1; idle(25);

        // full queue pushed in the same cycle as a write ACK
        auto_ack = 0;
        wreg(2'd0, 16'h0300); idle(3);
        wreg(2'd1, 16'hB001); wreg(2'd1, 16'hB002); idle(1);
        ack1(); idle(3);
        drive(0, 1, 0, 2'd1, 16'hB003, 1);
        rreg(2'd3); idle(1);
        auto_ack = 1; idle(30);

        // reset in the middle of a write, then a stray ACK
        auto_ack = 0;
        wreg(2'd0, 16'h4444); idle(3); ack1(); idle(1);
        wreg(2'd1, 16'hC001); wreg(2'd1, 16'hC002); idle(2);
        drive(1, 0, 0, 2'd0, 16'h0, 0);
        drive(0, 0, 0, 2'd0, 16'h0, 1);
        check_reset_outputs("mid_rst");
        idle(4);

        // randomized traffic
        auto_ack = 1;
        repeat (800) begin
            r = $urandom_range(0, 99);
            if      (r < 35) wreg(2'd1, 16'($urandom));
            else if (r < 42) wreg(2'd0, 16'($urandom));
            else if (r < 48) begin
                case ($urandom_range(0, 3))
                    0:       wreg(2'd2, 16'h0001);
                    1:       wreg(2'd2, 16'hFFFF);
                    2:       wreg(2'd2, 16'($urandom_range(0, 8)));
                    default: wreg(2'd2, 16'($urandom));
                endcase
            end
            else if (r < 60) rreg(2'd1);
            else if (r < 64) rreg(2'd3);
            else if (r < 67) wreg(2'd3, 16'($urandom));
            else             idle(1);
        end
        idle(40);
        check("acc_leftover", 32'(exp_acc.size()), 32'd0);
        check("queue_drained", 32'(mq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
